// File: rtl/data_sram_bridge.sv
// Data-side SRAM bridge: steers CPU accesses to the data RAM or to a small
// config register block, returning read data with the RAM's one-cycle latency.
module data_sram_bridge #(
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
    parameter logic [31:0] CONF_MASK = 32'hffff_0000,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_data_en,
    input  logic [3:0]        cpu_data_wen,
    input  logic [31:0]       cpu_data_addr,
    input  logic [31:0]       cpu_data_wdata,
    output logic [31:0]       cpu_data_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic [31:0]       num_data
);

    localparam logic [13:0] OFF_LED     = 14'h0000;
    localparam logic [13:0] OFF_SWITCH  = 14'h0001;
    localparam logic [13:0] OFF_NUM     = 14'h0002;
    localparam logic [13:0] OFF_TIMER   = 14'h0003;
    localparam logic [13:0] OFF_SCRATCH = 14'h0004;

    logic              conf_hit;
    logic              conf_we;
    logic [13:0]       word_sel;
    logic [LED_W-1:0]  led_r;
    logic [31:0]       num_r;
    logic [31:0]       timer_r;
    logic [31:0]       scratch_r;
    logic [SW_W-1:0]   sw_sync1;
    logic [SW_W-1:0]   sw_sync2;
    logic [31:0]       conf_sel_data;
    logic              sel_conf_r;
    logic [31:0]       conf_rdata_r;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wen);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
        end
        return merged;
    endfunction

    assign conf_hit  = (cpu_data_addr & CONF_MASK) == CONF_BASE;
    assign conf_we   = cpu_data_en & conf_hit & (|cpu_data_wen);
    assign word_sel  = cpu_data_addr[15:2];

    assign ram_en    = cpu_data_en & ~conf_hit;
    assign ram_wen   = conf_hit ? 4'b0000 : cpu_data_wen;
    assign ram_addr  = cpu_data_addr;
    assign ram_wdata = cpu_data_wdata;

    // Register read mux; sampled before any same-cycle write lands.
    always_comb begin
        conf_sel_data = 32'h0;
        case (word_sel)
            OFF_LED:     conf_sel_data = 32'(led_r);
            OFF_SWITCH:  conf_sel_data = 32'(sw_sync2);
            OFF_NUM:     conf_sel_data = num_r;
            OFF_TIMER:   conf_sel_data = timer_r;
            OFF_SCRATCH: conf_sel_data = scratch_r;
            default:     conf_sel_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_r     <= '0;
            num_r     <= 32'h0;
            scratch_r <= 32'h0;
        end else if (conf_we) begin
            if (word_sel == OFF_LED) begin
                for (int b = 0; b < LED_W; b++) begin
                    if (cpu_data_wen[b/8]) led_r[b] <= cpu_data_wdata[b];
                end
            end
            if (word_sel == OFF_NUM)
                num_r <= merge_bytes(num_r, cpu_data_wdata, cpu_data_wen);
            if (word_sel == OFF_SCRATCH)
                scratch_r <= merge_bytes(scratch_r, cpu_data_wdata, cpu_data_wen);
        end
    end

    // A timer write replaces the increment for that cycle; counting resumes after.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            timer_r <= 32'h0;
        else if (conf_we && word_sel == OFF_TIMER)
            timer_r <= merge_bytes(timer_r, cpu_data_wdata, cpu_data_wen);
        else
            timer_r <= timer_r + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= switch;
            sw_sync2 <= sw_sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_conf_r   <= 1'b0;
            conf_rdata_r <= 32'h0;
        end else if (cpu_data_en) begin
            sel_conf_r   <= conf_hit;
            conf_rdata_r <= conf_sel_data;
        end
    end

    assign cpu_data_rdata = sel_conf_r ? conf_rdata_r : ram_rdata;
    assign led            = led_r;
    assign num_data       = num_r;

endmodule
